// File: rtl/csr_pkg.sv
// Shared CSR addresses, opcode/funct3 encodings and the tohost handshake state type.
package csr_pkg;
   localparam logic [11:0] CSR_TOHOST  = 12'h51E;
   localparam logic [11:0] CSR_CYCLE   = 12'hC00;
   localparam logic [11:0] CSR_INSTRET = 12'hC02;

   localparam logic [4:0]  OPC_SYSTEM  = 5'b11100;
   localparam logic [2:0]  FNC_CSRRW   = 3'b001;
   localparam logic [2:0]  FNC_CSRRWI  = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } th_state_e;
endpackage

// File: rtl/csr_counter.sv
// Free-running wrap-around event counter, cleared by async reset.
module csr_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;
endmodule

// File: rtl/csr_unit.sv
// Minimal CSR block: csrrw/csrrwi to tohost plus read-only cycle/instret counters,
// with a valid/ready handshake that back-pressures the pipeline on tohost overrun.
module csr_unit
   import csr_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst,
   input  logic        inst_valid,
   input  logic        stall,
   input  logic [31:0] rs1_data,
   input  logic        retire,
   output logic [31:0] csr_rdata,
   output logic [31:0] tohost,
   output logic        tohost_valid,
   input  logic        tohost_ready,
   output logic        stall_req,
   output logic        illegal_csr
);
   logic [CNT_W-1:0] cycle_cnt, instret_cnt;
   logic [11:0]      addr;
   logic [2:0]       funct3;
   logic             csr_op, sel_tohost, sel_cycle, sel_instret, commit;
   logic [31:0]      wdata;
   logic [31:0]      tohost_q, tohost_d;
   th_state_e        state_q, state_d;
   logic             unused_inst_bits;

   csr_counter #(.CNT_W(CNT_W)) u_cycle (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (1'b1),
      .count (cycle_cnt)
   );

   csr_counter #(.CNT_W(CNT_W)) u_instret (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (retire),
      .count (instret_cnt)
   );

   assign unused_inst_bits = ^{inst[11:7], inst[1:0]};

   assign addr   = inst[31:20];
   assign funct3 = inst[14:12];
   assign csr_op = inst_valid && (inst[6:2] == OPC_SYSTEM)
                   && ((funct3 == FNC_CSRRW) || (funct3 == FNC_CSRRWI));

   assign sel_tohost  = csr_op && (addr == CSR_TOHOST);
   assign sel_cycle   = csr_op && (addr == CSR_CYCLE);
   assign sel_instret = csr_op && (addr == CSR_INSTRET);

   // Every decoded op is a write, so counters and unknown addresses are always illegal.
   assign illegal_csr = csr_op && !sel_tohost;

   assign wdata = (funct3 == FNC_CSRRWI) ? {27'd0, inst[19:15]} : rs1_data;

   always_comb begin
      csr_rdata = '0;
      if (sel_tohost)       csr_rdata = tohost_q;
      else if (sel_cycle)   csr_rdata = cycle_cnt[31:0];
      else if (sel_instret) csr_rdata = instret_cnt[31:0];
   end

   // Overrun only while the old value is still unaccepted; stall is deliberately excluded.
   assign stall_req = (state_q == ST_PEND) && sel_tohost && !tohost_ready;
   assign commit    = sel_tohost && !stall && !stall_req;

   always_comb begin
      state_d  = state_q;
      tohost_d = tohost_q;
      if (commit) begin
         tohost_d = wdata;
         state_d  = ST_PEND;
      end else if ((state_q == ST_PEND) && tohost_ready) begin
         state_d  = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         tohost_q <= '0;
      end else begin
         state_q  <= state_d;
         tohost_q <= tohost_d;
      end
   end

   assign tohost       = tohost_q;
   assign tohost_valid = (state_q == ST_PEND);
endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: expectations are queued as stimulus is driven, then drained.
module tb_csr_unit;
   import csr_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst;
   logic        inst_valid;
   logic        stall;
   logic [31:0] rs1_data;
   logic        retire;
   logic [31:0] csr_rdata;
   logic [31:0] tohost;
   logic        tohost_valid;
   logic        tohost_ready;
   logic        stall_req;
   logic        illegal_csr;

   csr_unit #(.CNT_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .inst         (inst),
      .inst_valid   (inst_valid),
      .stall        (stall),
      .rs1_data     (rs1_data),
      .retire       (retire),
      .csr_rdata    (csr_rdata),
      .tohost       (tohost),
      .tohost_valid (tohost_valid),
      .tohost_ready (tohost_ready),
      .stall_req    (stall_req),
      .illegal_csr  (illegal_csr)
   );

   always #5 clk = ~clk;

   // Reference cycle count: rising edges seen since reset released.
   logic [31:0] ncyc = '0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ncyc = '0;
      else        ncyc = ncyc + 1;
   end

   localparam int O_RDATA = 0, O_TOHOST = 1, O_VALID = 2, O_STALLREQ = 3, O_ILLEGAL = 4;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic logic [31:0] mk(logic [11:0] a, logic [4:0] r, logic [2:0] f);
      return {a, r, f, 5'd1, 7'b1110011};
   endfunction

   function automatic logic [31:0] observe(int sel);
      case (sel)
         O_RDATA:    return csr_rdata;
         O_TOHOST:   return tohost;
         O_VALID:    return {31'd0, tohost_valid};
         O_STALLREQ: return {31'd0, stall_req};
         default:    return {31'd0, illegal_csr};
      endcase
   endfunction

   task automatic push_exp(string tag, int sel, logic [31:0] e);
      exp_t x;
      x.tag = tag; x.sel = sel; x.exp = e;
      sb.push_back(x);
   endtask

   task automatic drain();
      exp_t        x;
      logic [31:0] o;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         o = observe(x.sel);
         n_total++;
         assert (o === x.exp) n_pass++;
         else $error("FAIL %s: observed %h expected %h", x.tag, o, x.exp);
      end
   endtask

   task automatic op(logic [31:0] i, logic [31:0] rs1);
      inst = i; inst_valid = 1'b1; rs1_data = rs1;
   endtask

   task automatic nop();
      inst = '0; inst_valid = 1'b0; rs1_data = '0;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; retire = 1'b0; tohost_ready = 1'b0;
      nop();
      repeat (3) @(negedge clk);
      push_exp("rst_valid", O_VALID, 0);
      push_exp("rst_tohost", O_TOHOST, 0);
      push_exp("rst_stallreq", O_STALLREQ, 0);
      push_exp("rst_rdata", O_RDATA, 0);
      #1 drain();

      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      op(mk(CSR_CYCLE, 5'd0, FNC_CSRRW), 32'h0);
      push_exp("cycle_10", O_RDATA, 10);
      push_exp("cycle_wr_illegal", O_ILLEGAL, 1);
      push_exp("idle_valid", O_VALID, 0);
      #1 drain();

      @(negedge clk);
      op(mk(CSR_INSTRET, 5'd0, FNC_CSRRW), 32'h0);
      push_exp("instret_0", O_RDATA, 0);
      #1 drain();

      // csrrwi tohost, 7
      @(negedge clk);
      op(mk(CSR_TOHOST, 5'd7, FNC_CSRRWI), 32'hFFFF_FFFF);
      push_exp("wri_rdata_old", O_RDATA, 0);
      push_exp("wri_legal", O_ILLEGAL, 0);
      push_exp("wri_nostall", O_STALLREQ, 0);
      #1 drain();
      @(negedge clk);
      nop();
      push_exp("wri_tohost", O_TOHOST, 7);
      push_exp("wri_valid", O_VALID, 1);
      #1 drain();

      // Overrun: write while PEND and host not ready.
      @(negedge clk);
      op(mk(CSR_TOHOST, 5'd1, FNC_CSRRW), 32'hDEAD_BEEF);
      push_exp("ovr_stallreq", O_STALLREQ, 1);
      push_exp("ovr_rdata", O_RDATA, 7);
      #1 drain();
      @(negedge clk);
      push_exp("ovr_hold_tohost", O_TOHOST, 7);
      push_exp("ovr_hold_valid", O_VALID, 1);
      push_exp("ovr_hold_stallreq", O_STALLREQ, 1);
      #1 drain();
      tohost_ready = 1'b1;
      push_exp("ovr_ready_stallreq", O_STALLREQ, 0);
      #1 drain();
      @(negedge clk);
      nop(); tohost_ready = 1'b0;
      push_exp("ovr_new_tohost", O_TOHOST, 32'hDEAD_BEEF);
      push_exp("ovr_new_valid", O_VALID, 1);
      push_exp("ovr_new_stallreq", O_STALLREQ, 0);
      #1 drain();

      // Plain handshake completion.
      tohost_ready = 1'b1;
      @(negedge clk);
      tohost_ready = 1'b0;
      push_exp("hs_done_valid", O_VALID, 0);
      push_exp("hs_done_tohost", O_TOHOST, 32'hDEAD_BEEF);
      #1 drain();

      // Illegal accesses must not change anything.
      op(mk(CSR_CYCLE, 5'd2, FNC_CSRRW), 32'h1234_5678);
      push_exp("ill_c00", O_ILLEGAL, 1);
      #1 drain();
      @(negedge clk);
      op(mk(12'h123, 5'd2, FNC_CSRRW), 32'h1234_5678);
      push_exp("ill_123", O_ILLEGAL, 1);
      push_exp("ill_123_rdata", O_RDATA, 0);
      #1 drain();
      @(negedge clk);
      nop();
      push_exp("ill_tohost", O_TOHOST, 32'hDEAD_BEEF);
      push_exp("ill_valid", O_VALID, 0);
      #1 drain();

      // Stalled write does not commit.
      stall = 1'b1;
      op(mk(CSR_TOHOST, 5'd3, FNC_CSRRW), 32'h0000_0055);
      push_exp("stall_nostallreq", O_STALLREQ, 0);
      #1 drain();
      @(negedge clk);
      stall = 1'b0; nop();
      push_exp("stall_tohost", O_TOHOST, 32'hDEAD_BEEF);
      push_exp("stall_valid", O_VALID, 0);
      #1 drain();

      // csrrs and bubbles are not CSR ops here.
      op({CSR_TOHOST, 5'd3, 3'b010, 5'd1, 7'b1110011}, 32'h1);
      push_exp("csrrs_rdata", O_RDATA, 0);
      push_exp("csrrs_illegal", O_ILLEGAL, 0);
      #1 drain();
      @(negedge clk);
      op(mk(12'h123, 5'd0, FNC_CSRRW), 32'h0);
      inst_valid = 1'b0;
      push_exp("bubble_illegal", O_ILLEGAL, 0);
      #1 drain();

      // Retire five instructions, with gaps.
      nop();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); retire = 1'b1;
         @(negedge clk); retire = 1'b0;
      end
      op(mk(CSR_INSTRET, 5'd0, FNC_CSRRW), 32'h0);
      push_exp("instret_5", O_RDATA, 5);
      #1 drain();
      @(negedge clk);
      op(mk(CSR_CYCLE, 5'd0, FNC_CSRRW), 32'h0);
      #1 push_exp("cycle_running", O_RDATA, ncyc);
      drain();

      // Wrap of the 32-bit cycle counter.
      @(negedge clk);
      force dut.u_cycle.count_q = 32'hFFFF_FFFE;
      #1 release dut.u_cycle.count_q;
      push_exp("wrap_pre", O_RDATA, 32'hFFFF_FFFE);
      #1 drain();
      @(negedge clk);
      push_exp("wrap_max", O_RDATA, 32'hFFFF_FFFF);
      #1 drain();
      @(negedge clk);
      push_exp("wrap_zero", O_RDATA, 0);
      #1 drain();

      // Async reset in the middle of a pending handshake.
      @(negedge clk);
      op(mk(CSR_TOHOST, 5'd3, FNC_CSRRWI), 32'h0);
      @(negedge clk);
      nop();
      push_exp("pend_valid", O_VALID, 1);
      push_exp("pend_tohost", O_TOHOST, 3);
      #1 drain();
      #1 rst_n = 1'b0;
      push_exp("arst_valid", O_VALID, 0);
      push_exp("arst_tohost", O_TOHOST, 0);
      push_exp("arst_stallreq", O_STALLREQ, 0);
      #1 drain();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
